// File: rtl/d_ff_pipeline_with_ce_and_clear_if.sv
// rtl/d_ff_pipeline_with_ce_and_clear_if.sv - signal bundle for the CE/clear delay line
// D_PIPE_STALL_COUNT_EN adds the stall_cnt output to the bundle.
interface d_ff_pipeline_with_ce_and_clear_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             ce;
  logic             clr;
  logic [WIDTH-1:0] D;
  logic             D_valid;
  logic [WIDTH-1:0] Q;
  logic             Q_valid;
  logic [OCC_W-1:0] occupancy;
`ifdef D_PIPE_STALL_COUNT_EN
  logic [15:0]      stall_cnt;

  modport master (output ce, clr, D, D_valid,
                  input  Q, Q_valid, occupancy, stall_cnt);
  modport slave  (input  ce, clr, D, D_valid,
                  output Q, Q_valid, occupancy, stall_cnt);
`else
  modport master (output ce, clr, D, D_valid,
                  input  Q, Q_valid, occupancy);
  modport slave  (input  ce, clr, D, D_valid,
                  output Q, Q_valid, occupancy);
`endif
endinterface

// File: rtl/d_ff_pipeline_with_ce_and_clear.sv
// rtl/d_ff_pipeline_with_ce_and_clear.sv - WIDTH x DEPTH delay line with CE, sync clear and occupancy
// D_PIPE_STALL_COUNT_EN adds a saturating count of stalled edges with data in flight.
module d_ff_pipeline_with_ce_and_clear #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                              Clk,
  input logic                              reset,
  d_ff_pipeline_with_ce_and_clear_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
      valid_d = '0;
      occ_d   = '0;
    end else if (bus.ce) begin
      // bubbles are zero-filled so Q never shows stale data
      stage_d[0] = bus.D_valid ? bus.D : '0;
      valid_d[0] = bus.D_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      occ_d = occ_q + OCC_W'(bus.D_valid) - OCC_W'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.Q         = stage_q[DEPTH-1];
  assign bus.Q_valid   = valid_q[DEPTH-1];
  assign bus.occupancy = occ_q;

`ifdef D_PIPE_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.clr) begin
      stall_d = '0;
    end else if (!bus.ce && (occ_q != '0) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`endif

  ce_clr_known_a : assert property (@(posedge Clk) disable iff (!reset)
                                    !$isunknown({bus.ce, bus.clr}));
endmodule
